// File: rtl/dt_rotator_pkg.sv
// Shared definitions for the DTEngine pipelined rotator: direction codes,
// per-stage control payload and the width-consistency check.
package dt_rotator_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int DT_ROT_DATA_WIDTH = 32;
    localparam int DT_ROT_SHIFT_BITS = 5;
    localparam int DT_ROT_TAG_WIDTH  = 8;

    // Per-word control carried alongside data/amount/tag through every stage.
    typedef struct packed {
        logic dir;
        logic logical;
    } stage_ctrl_t;

    function automatic bit shift_bits_ok(input int data_width, input int shift_bits);
        return (data_width >= 2) && (shift_bits >= 1) && (shift_bits < 31) &&
               ((1 << shift_bits) == data_width);
    endfunction

endpackage

// File: rtl/dt_rotator_stage.sv
// One registered rotator stage: conditional rotate/shift by 2**STAGE_IDX,
// its own valid bit and the bubble-collapsing load enable.
// Zero-fill mode is compiled in only with DT_ROTATOR_LOGICAL_SHIFT_EN.
module dt_rotator_stage
    import dt_rotator_pkg::*;
#(
    parameter int DATA_WIDTH = DT_ROT_DATA_WIDTH,
    parameter int SHIFT_BITS = DT_ROT_SHIFT_BITS,
    parameter int TAG_WIDTH  = DT_ROT_TAG_WIDTH,
    parameter int STAGE_IDX  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [SHIFT_BITS-1:0] i_amount,
    input  stage_ctrl_t           i_ctrl,
    input  logic [TAG_WIDTH-1:0]  i_tag,
    input  logic                  i_adv,
    output logic                  o_load,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [SHIFT_BITS-1:0] o_amount,
    output stage_ctrl_t           o_ctrl,
    output logic [TAG_WIDTH-1:0]  o_tag
);

    localparam int STEP = 1 << STAGE_IDX;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [SHIFT_BITS-1:0] amount;
        stage_ctrl_t           ctrl;
        logic [TAG_WIDTH-1:0]  tag;
    } payload_t;

    logic                  r_valid;
    payload_t              r_pay;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_shl;
    logic [DATA_WIDTH-1:0] w_shr;
    logic [DATA_WIDTH-1:0] w_rot_l;
    logic [DATA_WIDTH-1:0] w_rot_r;
    logic [DATA_WIDTH-1:0] w_next_data;

    // A stage may take a new word when empty or when its occupant moves on.
    assign w_load  = !r_valid || i_adv;

    assign w_shl   = i_data << STEP;
    assign w_shr   = i_data >> STEP;
    assign w_rot_l = w_shl | (i_data >> (DATA_WIDTH - STEP));
    assign w_rot_r = w_shr | (i_data << (DATA_WIDTH - STEP));

    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_next_data = i_data;
        if (i_amount[STAGE_IDX]) begin
            w_next_data = (i_ctrl.dir == DIR_RIGHT) ? w_rot_r : w_rot_l;
`ifdef DT_ROTATOR_LOGICAL_SHIFT_EN
            if (i_ctrl.logical) begin
                w_next_data = (i_ctrl.dir == DIR_RIGHT) ? w_shr : w_shl;
            end
`endif
        end
    end

`ifndef DT_ROTATOR_LOGICAL_SHIFT_EN
    logic w_unused_logical;
    assign w_unused_logical = i_ctrl.logical;
`endif

    // NOTE: state updates use non-blocking assignments so every stage samples
    // its upstream neighbour's pre-edge value; payload is reset so outputs read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pay   <= '0;
        end else if (w_load) begin
            r_valid      <= i_valid;
            r_pay.data   <= w_next_data;
            r_pay.amount <= i_amount;
            r_pay.ctrl   <= i_ctrl;
            r_pay.tag    <= i_tag;
        end
    end

    assign o_load   = w_load;
    assign o_valid  = r_valid;
    assign o_data   = r_pay.data;
    assign o_amount = r_pay.amount;
    assign o_ctrl   = r_pay.ctrl;
    assign o_tag    = r_pay.tag;

endmodule

// File: rtl/dt_pipelined_rotator.sv
// Fully pipelined barrel rotator with valid/ready flow control: SHIFT_BITS
// chained dt_rotator_stage instances. Optional in_logical port: DT_ROTATOR_LOGICAL_SHIFT_EN.
module dt_pipelined_rotator
    import dt_rotator_pkg::*;
#(
    parameter int DATA_WIDTH = DT_ROT_DATA_WIDTH,
    parameter int SHIFT_BITS = DT_ROT_SHIFT_BITS,
    parameter int TAG_WIDTH  = DT_ROT_TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [SHIFT_BITS-1:0] in_amount,
    input  logic                  in_dir,
`ifdef DT_ROTATOR_LOGICAL_SHIFT_EN
    input  logic                  in_logical,
`endif
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    localparam bit PARAMS_OK = shift_bits_ok(DATA_WIDTH, SHIFT_BITS);

    if (!PARAMS_OK) begin : g_param_check
        $error("dt_pipelined_rotator: DATA_WIDTH must be 2**SHIFT_BITS and at least 2");
    end

    // Index 0 is the input port side; index k+1 is the output of stage k.
    logic                  w_valid  [0:SHIFT_BITS];
    logic                  w_load   [0:SHIFT_BITS];
    logic [DATA_WIDTH-1:0] w_data   [0:SHIFT_BITS];
    logic [SHIFT_BITS-1:0] w_amount [0:SHIFT_BITS];
    stage_ctrl_t           w_ctrl   [0:SHIFT_BITS];
    logic [TAG_WIDTH-1:0]  w_tag    [0:SHIFT_BITS];

    assign w_valid[0]  = in_valid;
    assign w_data[0]   = in_data;
    assign w_amount[0] = in_amount;
    assign w_tag[0]    = in_tag;
    assign w_ctrl[0].dir = in_dir;
`ifdef DT_ROTATOR_LOGICAL_SHIFT_EN
    assign w_ctrl[0].logical = in_logical;
`else
    assign w_ctrl[0].logical = 1'b0;
`endif

    assign w_load[SHIFT_BITS] = out_ready;

    for (genvar k = 0; k < SHIFT_BITS; k++) begin : g_stage
        dt_rotator_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .SHIFT_BITS (SHIFT_BITS),
            .TAG_WIDTH  (TAG_WIDTH),
            .STAGE_IDX  (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .i_valid  (w_valid[k]),
            .i_data   (w_data[k]),
            .i_amount (w_amount[k]),
            .i_ctrl   (w_ctrl[k]),
            .i_tag    (w_tag[k]),
            .i_adv    (w_load[k+1]),
            .o_load   (w_load[k]),
            .o_valid  (w_valid[k+1]),
            .o_data   (w_data[k+1]),
            .o_amount (w_amount[k+1]),
            .o_ctrl   (w_ctrl[k+1]),
            .o_tag    (w_tag[k+1])
        );
    end

    // in_ready depends only on stage valids and out_ready, never on in_valid.
    assign in_ready  = w_load[0];
    assign out_valid = w_valid[SHIFT_BITS];
    assign out_data  = w_data[SHIFT_BITS];
    assign out_tag   = w_tag[SHIFT_BITS];

    logic w_unused_tail;
    assign w_unused_tail = ^{w_amount[SHIFT_BITS], w_ctrl[SHIFT_BITS]};

endmodule

// File: tb/tb_dt_pipelined_rotator.sv
// Scoreboard bench for dt_pipelined_rotator (8-bit data, 3 stages, 4-bit tag).
// Logical-shift vectors are added when DT_ROTATOR_LOGICAL_SHIFT_EN is defined.
module tb_dt_pipelined_rotator;
    import dt_rotator_pkg::*;

    localparam int DW = 8;
    localparam int SB = 3;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [SB-1:0] in_amount;
    logic          in_dir;
    logic          in_logical;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    dt_pipelined_rotator #(
        .DATA_WIDTH (DW),
        .SHIFT_BITS (SB),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amount  (in_amount),
        .in_dir     (in_dir),
`ifdef DT_ROTATOR_LOGICAL_SHIFT_EN
        .in_logical (in_logical),
`endif
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        int            acc_cyc;
        bit            chk_lat;
    } exp_t;

    exp_t          sb_q[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            acc_cnt = 0;
    int            out_cnt = 0;
    int            last_out_cyc = 0;
    logic [DW-1:0] drv_exp = '0;
    bit            drv_chk_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Independent bit-by-bit reference of rotate / logical shift.
    function automatic logic [DW-1:0] model_rot(input logic [DW-1:0] d, input int amt,
                                                input logic dir, input logic lg);
        logic [DW-1:0] r = '0;
        for (int i = 0; i < DW; i++) begin
            int dst = dir ? i - amt : i + amt;
            if (dst >= 0 && dst < DW) r[dst] = d[i];
            else if (!lg) r[(dst + DW) % DW] = d[i];
        end
        return r;
    endfunction

    // Input side: record the expected response of every accepted word.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            sb_q.push_back('{data: drv_exp, tag: in_tag, acc_cyc: cyc, chk_lat: drv_chk_lat});
            acc_cnt++;
        end
    end

    // Output side: compare every transferred result against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                check("spurious_out_valid", out_valid, 0);
            end else begin
                e = sb_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_tag", out_tag, e.tag);
                if (e.chk_lat) check("latency", cyc - e.acc_cyc, SB);
            end
            out_cnt++;
            last_out_cyc = cyc;
        end
    end

    task automatic drive(input logic [DW-1:0] d, input logic [SB-1:0] amt, input logic dir,
                         input logic [TW-1:0] tag, input logic [DW-1:0] exp, input bit lat,
                         input logic lg);
        in_valid   = 1'b1;
        in_data    = d;
        in_amount  = amt;
        in_dir     = dir;
        in_tag     = tag;
        in_logical = lg;
        drv_exp    = exp;
        drv_chk_lat = lat;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [SB-1:0] amt, input logic dir,
                        input logic [TW-1:0] tag, input logic [DW-1:0] exp, input bit lat,
                        input logic lg = 1'b0);
        drive(d, amt, dir, tag, exp, lat, lg);
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout_in_ready", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400 && sb_q.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_queue_empty", sb_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] bp_d   [0:3];
        logic [SB-1:0] bp_a   [0:3];
        logic          bp_dir [0:3];
        logic [DW-1:0] bp_e   [0:3];
        logic [DW-1:0] cap_data;
        logic [TW-1:0] cap_tag;
        logic [DW-1:0] rd;
        logic [SB-1:0] ra;
        logic          rdir;
        int            first_acc, out0, acc0, k;
        bit            accepted;

        bp_d = '{8'h12, 8'h81, 8'hC0, 8'h07};
        bp_a = '{3'd2, 3'd4, 3'd6, 3'd3};
        bp_dir = '{DIR_LEFT, DIR_RIGHT, DIR_LEFT, DIR_LEFT};
        bp_e = '{8'h48, 8'h18, 8'h30, 8'h38};

        in_valid = 1'b0; in_data = '0; in_amount = '0; in_dir = 1'b0;
        in_logical = 1'b0; in_tag = '0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed rotates with hand-computed results
        send(8'h81, 3'd1, DIR_LEFT,  4'h5, 8'h03, 1'b1);
        idle(4);
        send(8'h0F, 3'd3, DIR_RIGHT, 4'h6, 8'hE1, 1'b1);
        idle(4);
        send(8'hA5, 3'd0, DIR_LEFT,  4'h7, 8'hA5, 1'b1);
        send(8'hA5, 3'd0, DIR_RIGHT, 4'h8, 8'hA5, 1'b1);
        send(8'h01, 3'd7, DIR_LEFT,  4'h9, 8'h80, 1'b1);
        send(8'h01, 3'd1, DIR_RIGHT, 4'hA, 8'h80, 1'b1);
        send(8'h3C, 3'd4, DIR_LEFT,  4'hB, 8'hC3, 1'b1);
        send(8'hB4, 3'd3, DIR_RIGHT, 4'hC, 8'h96, 1'b1);
        send(8'hB4, 3'd5, DIR_LEFT,  4'hD, 8'h96, 1'b1);
        wait_drain();

        // Full-rate streaming against the reference model
        idle(2);
        first_acc = cyc;
        out0 = out_cnt;
        for (int i = 0; i < 256; i++) begin
            rd   = DW'($urandom);
            ra   = SB'($urandom_range(0, 7));
            rdir = 1'($urandom_range(0, 1));
            send(rd, ra, rdir, i[TW-1:0], model_rot(rd, int'(ra), rdir, 1'b0), 1'b1);
        end
        wait_drain();
        check("stream_count", out_cnt - out0, 256);
        check("stream_rate", last_out_cyc - first_acc, 255 + SB);

        // Backpressure: fill the pipe with in_valid held high
        idle(2);
        out_ready = 1'b0;
        acc0 = acc_cnt;
        k = 0;
        drive(bp_d[0], bp_a[0], bp_dir[0], 4'h1, bp_e[0], 1'b0, 1'b0);
        repeat (6) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk); #1;
            if (accepted && k < 3) begin
                k++;
                drive(bp_d[k], bp_a[k], bp_dir[k], TW'(k + 1), bp_e[k], 1'b0, 1'b0);
            end
        end
        check("bp_accepted", acc_cnt - acc0, 3);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        cap_data = out_data;
        cap_tag  = out_tag;
        check("bp_head_data", cap_data, 8'h48);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_stable_data", out_data, cap_data);
        check("bp_stable_tag", out_tag, cap_tag);
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();
        check("bp_total_accepted", acc_cnt - acc0, 4);

        // Bubble collapse under a stalled output
        idle(2);
        out_ready = 1'b0;
        send(8'h5A, 3'd1, DIR_LEFT,  4'h1, 8'hB4, 1'b0);
        idle(2);
        send(8'h33, 3'd2, DIR_RIGHT, 4'h2, 8'hCC, 1'b0);
        check("bubble_in_ready", in_ready, 1);
        check("bubble_out_valid", out_valid, 1);
        check("bubble_head_data", out_data, 8'hB4);
        idle(1);
        check("bubble_in_ready_2", in_ready, 1);
        out_ready = 1'b1;
        wait_drain();

        // Asynchronous reset with a full pipe
        idle(2);
        out_ready = 1'b0;
        send(8'h11, 3'd1, DIR_LEFT,  4'h3, 8'h22, 1'b0);
        send(8'h44, 3'd2, DIR_RIGHT, 4'h4, 8'h11, 1'b0);
        send(8'h90, 3'd3, DIR_LEFT,  4'h5, 8'h84, 1'b0);
        check("pre_rst_out_valid", out_valid, 1);
        check("pre_rst_out_data", out_data, 8'h22);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_out_tag", out_tag, 0);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_no_stale", out_valid, 0);

`ifdef DT_ROTATOR_LOGICAL_SHIFT_EN
        // Zero-fill shifts
        send(8'h81, 3'd1, DIR_LEFT,  4'h6, 8'h02, 1'b1, 1'b1);
        send(8'h81, 3'd1, DIR_RIGHT, 4'h7, 8'h40, 1'b1, 1'b1);
        send(8'hFF, 3'd5, DIR_LEFT,  4'h8, 8'hE0, 1'b1, 1'b1);
        send(8'h81, 3'd1, DIR_LEFT,  4'h9, 8'h03, 1'b1, 1'b0);
        wait_drain();
`endif

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
